// File: rtl/block_data_memory_pkg.sv
// Shared types and default sizing for the block data memory slice.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_ADDR_WIDTH  = 6;
    localparam int DMEM_BLOCK_BYTES = 4;
    localparam int DMEM_LATENCY     = 5;

    // Latency counter width; a single cycle of latency still needs one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/block_data_memory_dmem_array.sv
// Byte-organised storage with one block-wide synchronous port, registered read
// data and asynchronous clear of every byte.
module dmem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter int BLOCK_BYTES = DMEM_BLOCK_BYTES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [8*BLOCK_BYTES-1:0] wdata,
    output logic [8*BLOCK_BYTES-1:0] rdata
);

    localparam int DEPTH = (2 ** ADDR_WIDTH) * BLOCK_BYTES;
    localparam int BA_W  = ADDR_WIDTH + $clog2(BLOCK_BYTES);

    logic [7:0]               mem_q [DEPTH];
    logic [7:0]               mem_d [DEPTH];
    logic [8*BLOCK_BYTES-1:0] rdata_q;
    logic [8*BLOCK_BYTES-1:0] rdata_d;

    // Byte k of block a lives at byte address {a, k}: little-endian inside a block.
    function automatic logic [BA_W-1:0] byte_index(input logic [ADDR_WIDTH-1:0] a, input int k);
        return BA_W'(int'(a) * BLOCK_BYTES + k);
    endfunction

    // Next-state of the storage bytes and the read data register.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (wr_en) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                mem_d[byte_index(addr, k)] = wdata[8*k +: 8];
            end
        end else if (rd_en) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                rdata_d[8*k +: 8] = mem_q[byte_index(addr, k)];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage and read data registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/block_data_memory.sv
// Block data memory: captures a read or write request, stalls the requester for
// LATENCY cycles, performs the block access, then releases for one cycle.
module block_data_memory
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter int BLOCK_BYTES = DMEM_BLOCK_BYTES,
    parameter int LATENCY     = DMEM_LATENCY
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_WIDTH-1:0]    address,
    input  logic [8*BLOCK_BYTES-1:0] writedata,
    output logic [8*BLOCK_BYTES-1:0] readdata,
    output logic                     busywait,
    output logic                     error
);

    localparam int DATA_W = 8 * BLOCK_BYTES;
    localparam int CNT_W  = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_t             state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    error_q, error_d;
    logic                    fire_s;

    // FSM, latency counter, request capture and sticky conflict flag.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (read ^ write) begin
                    state_d    = BUSY;
                    count_d    = CNT_LOAD;
                    op_write_d = write;
                    addr_d     = address;
                    wdata_d    = writedata;
                    error_d    = 1'b0;
                end else if (read & write) begin
                    error_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and capture registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
        end
    end

    // The access happens on the edge that leaves BUSY with the counter exhausted.
    assign fire_s = (state_q == BUSY) && (count_q == '0);

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_BYTES(BLOCK_BYTES)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .wr_en(fire_s & op_write_q),
        .rd_en(fire_s & ~op_write_q),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(readdata)
    );

    // Stall is raised in the request cycle itself so the requester never runs ahead.
    assign busywait = ~reset & ((state_q == BUSY) || ((state_q == IDLE) && (read ^ write)));
    assign error    = error_q;

endmodule
